carry_chain_seq: RTL and testbench

Multi-beat carry-chaining sequencer that sits directly upstream of the ripple adder's consumers. It accepts d-bit operand slices over a valid/ready handshake and adds each slice with a ripple chain of full_adder cells. It registers the slice sum and carry-out, and feeds the carry-out into the next slice, so operands wider than d are added least-significant slice first. The result stream goes out over a second valid/ready handshake with one cycle of latency.

---
 rtl/carry_chain_seq.sv | 81 ++++++++
 tb/tb_carry_chain_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/carry_chain_seq.sv
// carry_chain_seq: multi-slice ripple adder sequencer with carry chaining across slices; optional sticky err port via CCS_ERR_EN
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module carry_chain_seq #(
  parameter int d = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [d-1:0] a,
  input  logic [d-1:0] b,
  input  logic         cin,
  input  logic         first,
  input  logic         last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [d-1:0] sum,
  output logic         cout,
  output logic         out_last,
  output logic [7:0]   out_beat
`ifdef CCS_ERR_EN
  ,
  output logic         err
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic creg;
  logic [d:0] c;
  logic [d-1:0] s;
  logic accept, xfer, fresh;
  logic [7:0] beat_nxt;
  assign in_ready = !rst & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign fresh    = (state == IDLE) | first;
  assign c[0]     = fresh ? cin : creg;
  assign beat_nxt = fresh ? 8'd0 : (out_beat == 8'd255 ? 8'd255 : out_beat + 8'd1);
  for (genvar i = 0; i < d; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  // sequencer state, carry register and registered result slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      creg      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_last  <= 1'b0;
      out_beat  <= 8'd0;
    end else if (accept) begin
      state     <= last ? IDLE : BUSY;
      creg      <= c[d];
      out_valid <= 1'b1;
      sum       <= s;
      cout      <= c[d];
      out_last  <= last;
      out_beat  <= beat_nxt;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end
`ifdef CCS_ERR_EN
  // sticky flag for a first marker that contradicts the open/closed operation state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (accept && ((state == IDLE) != first)) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_carry_chain_seq.sv
// tb_carry_chain_seq: directed self-checking bench for carry_chain_seq (d=4); checks err when CCS_ERR_EN is defined
module tb_carry_chain_seq;
  localparam int d = 4;
  logic clk = 1'b0, rst, in_valid, in_ready, cin, first, last, out_valid, out_ready, cout, out_last;
  logic [d-1:0] a, b, sum;
  logic [7:0] out_beat;
`ifdef CCS_ERR_EN
  logic err;
`endif
  int n_chk = 0, n_fail = 0;

  carry_chain_seq #(.d(d)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .first(first), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .out_last(out_last), .out_beat(out_beat)
`ifdef CCS_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [d-1:0] ta, input logic [d-1:0] tb, input logic tc, input logic tf, input logic tl);
    in_valid = 1'b1; a = ta; b = tb; cin = tc; first = tf; last = tl;
    @(posedge clk); #1;
  endtask

  task automatic out_chk(input string tag, input logic [d-1:0] es, input logic ec, input logic el, input logic [7:0] eb);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".last"}, out_last, el);
    chk({tag, ".beat"}, out_beat, eb);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; first = 1'b0; last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.sum", sum, 4'h0);
    chk("rst.beat", out_beat, 8'd0);
    chk("rst.in_ready", in_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1 chk("idle.in_ready", in_ready, 1'b1);

    step(4'h9, 4'h8, 1'b1, 1'b1, 1'b1);
    out_chk("single", 4'h2, 1'b1, 1'b1, 8'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clear.valid", out_valid, 1'b0);
    chk("clear.sum_hold", sum, 4'h2);

    step(4'h5, 4'hC, 1'b0, 1'b1, 1'b0);
    out_chk("add8.s0", 4'h1, 1'b1, 1'b0, 8'd0);
    step(4'hA, 4'h6, 1'b0, 1'b0, 1'b1);
    out_chk("add8.s1", 4'h1, 1'b1, 1'b1, 8'd1);

    step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    out_chk("wrap.s0", 4'hF, 1'b1, 1'b0, 8'd0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    out_chk("wrap.s1", 4'h1, 1'b0, 1'b1, 8'd1);

    step(4'h2, 4'h3, 1'b0, 1'b1, 1'b0);
    out_chk("bp.s0", 4'h5, 1'b0, 1'b0, 8'd0);
    out_ready = 1'b0; a = 4'h1; b = 4'h1; first = 1'b0; last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.in_ready", in_ready, 1'b0);
      out_chk("bp.hold", 4'h5, 1'b0, 1'b0, 8'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_chk("bp.s1", 4'h2, 1'b0, 1'b1, 8'd1);

    step(4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    out_chk("rs.s0", 4'h0, 1'b1, 1'b0, 8'd0);
    step(4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
    out_chk("rs.restart", 4'h2, 1'b0, 1'b0, 8'd0);
`ifdef CCS_ERR_EN
    chk("rs.err", err, 1'b1);
`endif
    step(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    out_chk("rs.s1", 4'hE, 1'b1, 1'b0, 8'd1);
`ifdef CCS_ERR_EN
    chk("rs.err_sticky", err, 1'b1);
`endif

    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst.valid", out_valid, 1'b0);
    chk("arst.sum", sum, 4'h0);
    chk("arst.cout", cout, 1'b0);
    chk("arst.last", out_last, 1'b0);
    chk("arst.beat", out_beat, 8'd0);
    chk("arst.in_ready", in_ready, 1'b0);
`ifdef CCS_ERR_EN
    chk("arst.err", err, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;
    step(4'h3, 4'h4, 1'b0, 1'b0, 1'b1);
    out_chk("post_rst", 4'h7, 1'b0, 1'b1, 8'd0);
`ifdef CCS_ERR_EN
    chk("post_rst.err", err, 1'b1);
`endif

    step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 254; i++) step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("sat.beat254", out_beat, 8'd254);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("sat.beat255", out_beat, 8'd255);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("sat.hold255", out_beat, 8'd255);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
